// File: rtl/mips_core_units.sv
// Storage-and-compute units of the five-stage MIPS pipeline: 32x32 register file,
// 4096-word data memory and a combinational ALU, sharing only the clock and reset.
module mips_core_units (
  input  logic        clk,
  input  logic        reset,
  // register file
  input  logic [4:0]  grf_a1,
  input  logic [4:0]  grf_a2,
  input  logic [4:0]  grf_a3,
  input  logic [31:0] grf_wdata,
  input  logic        grf_wen,
  input  logic [31:0] grf_pc,
  output logic [31:0] grf_v1,
  output logic [31:0] grf_v2,
  // ALU
  input  logic [31:0] alu_v1,
  input  logic [31:0] alu_v2,
  input  logic [15:0] alu_imm16,
  input  logic [3:0]  alu_opt,
  output logic [31:0] alu_res,
  // data memory
  input  logic [11:0] dm_a,
  input  logic [31:0] dm_wdata,
  input  logic        dm_wen,
  input  logic [31:0] dm_pc,
  output logic [31:0] dm_v
);

  localparam int NumRegs  = 32;
  localparam int DmWords  = 4096;

  localparam logic [3:0] OptAdd  = 4'd0;
  localparam logic [3:0] OptSub  = 4'd1;
  localparam logic [3:0] OptAnd  = 4'd2;
  localparam logic [3:0] OptOri  = 4'd3;
  localparam logic [3:0] OptAddr = 4'd4;
  localparam logic [3:0] OptLui  = 4'd15;

  logic [31:0] grfRegs [NumRegs];
  logic [31:0] dmMem   [DmWords];
  logic        grfWrAct;

  // ---------------------------------------------------------------------------
  // ALU datapath: two's-complement wrap-around, no overflow detection.
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] aluCompute(
    input logic [3:0]  opt,
    input logic [31:0] v1,
    input logic [31:0] v2,
    input logic [15:0] imm
  );
    logic signed [31:0] opA;
    logic signed [31:0] opB;
    logic signed [31:0] immSext;
    logic        [31:0] immZext;
    logic        [31:0] res;
    opA     = signed'(v1);
    opB     = signed'(v2);
    immSext = signed'({{16{imm[15]}}, imm});
    immZext = {16'h0000, imm};
    case (opt)
      OptAdd:  res = unsigned'(opA + opB);
      OptSub:  res = unsigned'(opA - opB);
      OptAnd:  res = v1 & v2;
      OptOri:  res = v1 | immZext;
      OptAddr: res = unsigned'(opA + immSext);
      OptLui:  res = {imm, 16'h0000};
      default: res = 32'h0000_0000;
    endcase
    return res;
  endfunction

  assign alu_res = aluCompute(alu_opt, alu_v1, alu_v2, alu_imm16);

  // ---------------------------------------------------------------------------
  // GRF: $0 is hardwired to zero; a pending write is forwarded to the read ports
  // in the same cycle so RR sees the value RW is about to commit.
  // ---------------------------------------------------------------------------
  assign grfWrAct = grf_wen && (grf_a3 != 5'd0);

  always_comb begin
    grf_v1 = grfRegs[grf_a1];
    if (grf_a1 == 5'd0)
      grf_v1 = 32'h0000_0000;
    else if (grfWrAct && (grf_a3 == grf_a1))
      grf_v1 = grf_wdata;
  end

  always_comb begin
    grf_v2 = grfRegs[grf_a2];
    if (grf_a2 == 5'd0)
      grf_v2 = 32'h0000_0000;
    else if (grfWrAct && (grf_a3 == grf_a2))
      grf_v2 = grf_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NumRegs; i++)
        grfRegs[i] <= 32'h0000_0000;
    end else if (grfWrAct) begin
      grfRegs[grf_a3] <= grf_wdata;
`ifndef SYNTHESIS
      $display("@%h: $%d <= %h", grf_pc, grf_a3, grf_wdata);
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // DM: word-addressed, no bypass -- a same-cycle load sees the old word.
  // ---------------------------------------------------------------------------
  assign dm_v = dmMem[dm_a];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DmWords; i++)
        dmMem[i] <= 32'h0000_0000;
    end else if (dm_wen) begin
      dmMem[dm_a] <= dm_wdata;
`ifndef SYNTHESIS
      $display("@%h: *%h <= %h", dm_pc, {18'b0, dm_a, 2'b00}, dm_wdata);
`endif
    end
  end

endmodule

// File: tb/tb_mips_core_units.sv
// Self-checking bench for mips_core_units: ALU vector table plus hand-written
// GRF/DM sequences, all expectations queued on a scoreboard.
module tb_mips_core_units;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  grf_a1, grf_a2, grf_a3;
  logic [31:0] grf_wdata, grf_pc, grf_v1, grf_v2;
  logic        grf_wen;
  logic [31:0] alu_v1, alu_v2, alu_res;
  logic [15:0] alu_imm16;
  logic [3:0]  alu_opt;
  logic [11:0] dm_a;
  logic [31:0] dm_wdata, dm_pc, dm_v;
  logic        dm_wen;

  mips_core_units dut (
    .clk(clk), .reset(reset),
    .grf_a1(grf_a1), .grf_a2(grf_a2), .grf_a3(grf_a3),
    .grf_wdata(grf_wdata), .grf_wen(grf_wen), .grf_pc(grf_pc),
    .grf_v1(grf_v1), .grf_v2(grf_v2),
    .alu_v1(alu_v1), .alu_v2(alu_v2), .alu_imm16(alu_imm16),
    .alu_opt(alu_opt), .alu_res(alu_res),
    .dm_a(dm_a), .dm_wdata(dm_wdata), .dm_wen(dm_wen), .dm_pc(dm_pc),
    .dm_v(dm_v)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  opt;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [15:0] imm;
    logic [31:0] exp;
  } aluVec_t;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sbEntry_t;

  aluVec_t     aluTab [12];
  sbEntry_t    sbQ [$];
  int          compared   = 0;
  int          mismatched = 0;
  logic [31:0] regModel [32];

  task automatic expectVal(input string name, input logic [31:0] exp);
    sbEntry_t e;
    e.name = name;
    e.exp  = exp;
    sbQ.push_back(e);
  endtask

  task automatic checkVal(input logic [31:0] act);
    sbEntry_t e;
    compared++;
    if (sbQ.size() == 0) begin
      mismatched++;
      $display("FAIL scoreboard-underflow: got %h with nothing expected", act);
    end else begin
      e = sbQ.pop_front();
      if (act !== e.exp) begin
        mismatched++;
        $display("FAIL %s: got %h required %h", e.name, act, e.exp);
      end
    end
  endtask

  // Push the expectation, settle combinational logic, then compare.
  task automatic chk(input string name, input logic [31:0] exp, input int sel);
    expectVal(name, exp);
    #1;
    case (sel)
      0: checkVal(grf_v1);
      1: checkVal(grf_v2);
      2: checkVal(dm_v);
      default: checkVal(alu_res);
    endcase
  endtask

  task automatic tickAndIdle();
    @(posedge clk);
    #1;
    grf_wen = 1'b0;
    dm_wen  = 1'b0;
    reset   = 1'b0;
  endtask

  initial begin
    aluTab[0]  = '{4'd0,  32'h7FFF_FFFF, 32'h0000_0001, 16'h0000, 32'h8000_0000};
    aluTab[1]  = '{4'd1,  32'h0000_0000, 32'h0000_0001, 16'h0000, 32'hFFFF_FFFF};
    aluTab[2]  = '{4'd3,  32'hF000_0000, 32'h1234_5678, 16'h8001, 32'hF000_8001};
    aluTab[3]  = '{4'd4,  32'h0000_0010, 32'h5555_5555, 16'hFFFC, 32'h0000_000C};
    aluTab[4]  = '{4'd15, 32'h1111_1111, 32'h2222_2222, 16'hABCD, 32'hABCD_0000};
    aluTab[5]  = '{4'd7,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'hFFFF, 32'h0000_0000};
    aluTab[6]  = '{4'd2,  32'hF0F0_FF00, 32'h0FF0_F0F0, 16'h0000, 32'h00F0_F000};
    aluTab[7]  = '{4'd0,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'h0000, 32'hFFFF_FFFE};
    aluTab[8]  = '{4'd1,  32'h8000_0000, 32'h0000_0001, 16'h0000, 32'h7FFF_FFFF};
    aluTab[9]  = '{4'd4,  32'h0000_1000, 32'h0000_0000, 16'h7FFF, 32'h0000_8FFF};
    aluTab[10] = '{4'd5,  32'h1234_5678, 32'h8765_4321, 16'h1234, 32'h0000_0000};
    aluTab[11] = '{4'd14, 32'hDEAD_BEEF, 32'h0000_0001, 16'hBEEF, 32'h0000_0000};

    reset = 1'b1;
    grf_a1 = '0; grf_a2 = '0; grf_a3 = '0; grf_wdata = '0; grf_wen = 1'b0; grf_pc = '0;
    alu_v1 = '0; alu_v2 = '0; alu_imm16 = '0; alu_opt = '0;
    dm_a = '0; dm_wdata = '0; dm_wen = 1'b0; dm_pc = '0;
    for (int i = 0; i < 32; i++) regModel[i] = '0;

    // Reset state
    @(negedge clk);
    reset = 1'b1;
    tickAndIdle();
    grf_a1 = 5'd5; grf_a2 = 5'd31; dm_a = 12'd3;
    chk("reset-grf-v1", 32'h0, 0);
    chk("reset-grf-v2", 32'h0, 1);
    chk("reset-dm-3", 32'h0, 2);
    dm_a = 12'd4095;
    chk("reset-dm-4095", 32'h0, 2);

    // GRF write $5, visible via bypass before the edge and from storage after
    @(negedge clk);
    grf_wen = 1'b1; grf_a3 = 5'd5; grf_wdata = 32'h1234_5678; grf_pc = 32'h3000;
    grf_a1 = 5'd5; grf_a2 = 5'd6;
    chk("grf-w5-bypass", 32'h1234_5678, 0);
    chk("grf-w5-other-port", 32'h0, 1);
    tickAndIdle();
    regModel[5] = 32'h1234_5678;
    chk("grf-w5-readback", 32'h1234_5678, 0);

    // Write to $0 is discarded, no bypass either
    @(negedge clk);
    grf_wen = 1'b1; grf_a3 = 5'd0; grf_wdata = 32'hFFFF_FFFF; grf_a1 = 5'd0;
    chk("grf-zero-during", 32'h0, 0);
    tickAndIdle();
    chk("grf-zero-after", 32'h0, 0);

    // Bypass on port 2, $7
    @(negedge clk);
    grf_wen = 1'b1; grf_a3 = 5'd7; grf_wdata = 32'h0000_00AA; grf_a2 = 5'd7; grf_a1 = 5'd5;
    chk("grf-bypass-a2", 32'h0000_00AA, 1);
    chk("grf-bypass-a1-unaffected", 32'h1234_5678, 0);
    tickAndIdle();
    regModel[7] = 32'h0000_00AA;
    chk("grf-w7-readback", 32'h0000_00AA, 1);

    // Fill registers 1..31 and read back through both ports against the model
    for (int r = 1; r < 32; r++) begin
      @(negedge clk);
      grf_wen = 1'b1; grf_a3 = 5'(r); grf_wdata = $urandom; grf_pc = 32'h3100 + 32'(r * 4);
      regModel[r] = grf_wdata;
      tickAndIdle();
    end
    for (int r = 0; r < 32; r++) begin
      grf_a1 = 5'(r); grf_a2 = 5'(31 - r);
      chk($sformatf("grf-fill-v1-r%0d", r), regModel[r], 0);
      chk($sformatf("grf-fill-v2-r%0d", 31 - r), regModel[31 - r], 1);
    end

    // ALU vectors
    for (int k = 0; k < 12; k++) begin
      alu_opt = aluTab[k].opt; alu_v1 = aluTab[k].v1;
      alu_v2 = aluTab[k].v2; alu_imm16 = aluTab[k].imm;
      chk($sformatf("alu-vec%0d-opt%0d", k, aluTab[k].opt), aluTab[k].exp, 3);
    end

    // DM store: old value before the edge, new value after
    @(negedge clk);
    dm_a = 12'd3; dm_wdata = 32'hDEAD_BEEF; dm_wen = 1'b1; dm_pc = 32'h3004;
    chk("dm-3-before-edge", 32'h0, 2);
    tickAndIdle();
    chk("dm-3-after-edge", 32'hDEAD_BEEF, 2);

    // Same-address overwrite still returns the old word until the edge
    @(negedge clk);
    dm_wdata = 32'h0BAD_F00D; dm_wen = 1'b1;
    chk("dm-3-no-bypass", 32'hDEAD_BEEF, 2);
    tickAndIdle();
    chk("dm-3-overwrite", 32'h0BAD_F00D, 2);

    // Top address
    @(negedge clk);
    dm_a = 12'd4095; dm_wdata = 32'hCAFE_1234; dm_wen = 1'b1; dm_pc = 32'h3008;
    tickAndIdle();
    chk("dm-4095", 32'hCAFE_1234, 2);
    dm_a = 12'd3;
    chk("dm-3-untouched", 32'h0BAD_F00D, 2);

    // Reset overrides concurrent writes and clears everything
    @(negedge clk);
    reset = 1'b1;
    grf_wen = 1'b1; grf_a3 = 5'd9; grf_wdata = 32'h5A5A_5A5A;
    dm_wen = 1'b1; dm_a = 12'd100; dm_wdata = 32'hA5A5_A5A5;
    tickAndIdle();
    grf_a1 = 5'd9; grf_a2 = 5'd5;
    chk("rst-mid-grf9", 32'h0, 0);
    chk("rst-mid-grf5", 32'h0, 1);
    chk("rst-mid-dm100", 32'h0, 2);
    dm_a = 12'd3;
    chk("rst-mid-dm3", 32'h0, 2);
    dm_a = 12'd4095;
    chk("rst-mid-dm4095", 32'h0, 2);
    grf_a1 = 5'd31; grf_a2 = 5'd7;
    chk("rst-mid-grf31", 32'h0, 0);
    chk("rst-mid-grf7", 32'h0, 1);

    compared++;
    if (sbQ.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard-drain: got %0d pending entries required 0", sbQ.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
